// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA barrel shifter: one mux level per shift-amount bit, each level registered,
// with a valid/ready handshake and whole-pipe stall on output backpressure.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LEVELS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic             out_err
);

  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnSra = 6'b000011;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || LEVELS != $clog2(WIDTH)) begin : gParamCheck
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2; LEVELS is derived");
  end

  logic              advance;
  logic              inOpLegal;
  logic              inAmtLegal;
  logic              inErr;

  // Stage registers
  logic              validQ [LEVELS];
  logic              errQ   [LEVELS];
  logic              leftQ  [LEVELS];
  logic              fillQ  [LEVELS];
  logic [WIDTH-1:0]  dataQ  [LEVELS];
  logic [LEVELS-1:0] amtQ   [LEVELS];

  // What each level sees at its input
  logic              srcValid [LEVELS];
  logic              srcErr   [LEVELS];
  logic              srcLeft  [LEVELS];
  logic              srcFill  [LEVELS];
  logic [WIDTH-1:0]  srcData  [LEVELS];
  logic [LEVELS-1:0] srcAmt   [LEVELS];
  logic [WIDTH-1:0]  nextData [LEVELS];

  assign advance   = !validQ[LEVELS-1] || out_ready;
  assign in_ready  = advance && !rst;
  assign out_valid = validQ[LEVELS-1];
  assign dataOut   = dataQ[LEVELS-1];
  assign out_err   = errQ[LEVELS-1];

  always_comb begin
    inOpLegal  = (Signal == FnSll) || (Signal == FnSrl) || (Signal == FnSra);
    inAmtLegal = ((dataB >> LEVELS) == '0);
    inErr      = !(inOpLegal && inAmtLegal);
  end

  // Illegal ops enter as zero data with zero fill, so every later level keeps them at zero.
  always_comb begin
    srcValid[0] = in_valid;
    srcErr[0]   = inErr;
    srcLeft[0]  = (Signal == FnSll);
    srcFill[0]  = (Signal == FnSra) && dataA[WIDTH-1] && !inErr;
    srcData[0]  = inErr ? '0 : dataA;
    srcAmt[0]   = dataB[LEVELS-1:0];
    for (int k = 1; k < LEVELS; k++) begin
      srcValid[k] = validQ[k-1];
      srcErr[k]   = errQ[k-1];
      srcLeft[k]  = leftQ[k-1];
      srcFill[k]  = fillQ[k-1];
      srcData[k]  = dataQ[k-1];
      srcAmt[k]   = amtQ[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < LEVELS; k++) begin
      nextData[k] = srcData[k];
      if (srcAmt[k][k]) begin
        if (srcLeft[k]) begin
          nextData[k] = srcData[k] << (1 << k);
        end else begin
          nextData[k] = (srcData[k] >> (1 << k)) |
                        ({WIDTH{srcFill[k]}} & ~({WIDTH{1'b1}} >> (1 << k)));
        end
      end
    end
  end

  // The whole pipe moves as one unit; bubbles are never squeezed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LEVELS; k++) begin
        validQ[k] <= 1'b0;
        errQ[k]   <= 1'b0;
        leftQ[k]  <= 1'b0;
        fillQ[k]  <= 1'b0;
        dataQ[k]  <= '0;
        amtQ[k]   <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < LEVELS; k++) begin
        validQ[k] <= srcValid[k];
        errQ[k]   <= srcErr[k];
        leftQ[k]  <= srcLeft[k];
        fillQ[k]  <= srcFill[k];
        dataQ[k]  <= nextData[k];
        amtQ[k]   <= srcAmt[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: a 32-bit and an 8-bit instance, vector table plus
// hand-written streaming, back-to-back and reset sequences.
module tb_pipelined_barrel_shifter;

  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        inValid = 1'b0, inReady, outValid, outReady = 1'b1, outErr;
  logic [31:0] dataA = '0, dataB = '0, dataOut;
  logic [5:0]  sig = SLL;

  logic        inValid8 = 1'b0, inReady8, outValid8, outReady8 = 1'b1, outErr8;
  logic [7:0]  dataA8 = '0, dataB8 = '0, dataOut8;
  logic [5:0]  sig8 = SLL;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .dataA(dataA), .dataB(dataB),
    .Signal(sig), .out_valid(outValid), .out_ready(outReady), .dataOut(dataOut), .out_err(outErr)
  );

  pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8), .dataA(dataA8),
    .dataB(dataB8), .Signal(sig8), .out_valid(outValid8), .out_ready(outReady8),
    .dataOut(dataOut8), .out_err(outErr8)
  );

  typedef struct packed {
    bit          is8;
    logic [5:0]  sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  vec_t vecs[20];
  int   nVecs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Latency counts rising edges from the accepting edge (inclusive) to the first out_valid.
  task automatic runOne(input int idx, input vec_t v);
    int  lat;
    bit  seen;
    int  expLat;
    logic ov;
    logic [31:0] od;
    logic oe;
    expLat = v.is8 ? 3 : 5;
    seen = 1'b0;
    lat = 0;
    if (v.is8) begin
      inValid8 = 1'b1; dataA8 = v.a[7:0]; dataB8 = v.b[7:0]; sig8 = v.sig;
      check($sformatf("vec%0d in_ready", idx), {31'b0, inReady8}, 32'd1);
    end else begin
      inValid = 1'b1; dataA = v.a; dataB = v.b; sig = v.sig;
      check($sformatf("vec%0d in_ready", idx), {31'b0, inReady}, 32'd1);
    end
    cyc(1);
    inValid = 1'b0;
    inValid8 = 1'b0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      ov = v.is8 ? outValid8 : outValid;
      if (ov) begin
        seen = 1'b1;
        lat = c;
      end else begin
        cyc(1);
      end
    end
    od = v.is8 ? {24'b0, dataOut8} : dataOut;
    oe = v.is8 ? outErr8 : outErr;
    check($sformatf("vec%0d out_valid seen", idx), {31'b0, seen}, 32'd1);
    check($sformatf("vec%0d latency", idx), lat, expLat);
    check($sformatf("vec%0d dataOut", idx), od, v.expData);
    check($sformatf("vec%0d out_err", idx), {31'b0, oe}, {31'b0, v.expErr});
    cyc(1);
    ov = v.is8 ? outValid8 : outValid;
    check($sformatf("vec%0d single output", idx), {31'b0, ov}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int received;
    int issued;
    int extra;
    bit prevStall;
    logic [31:0] prevData;
    bit seen;

    nVecs = 0;
    vecs[nVecs++] = '{1'b0, SLL, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0};
    vecs[nVecs++] = '{1'b0, SRA, 32'h8000_00F0, 32'd4, 32'hF800_000F, 1'b0};
    vecs[nVecs++] = '{1'b0, SRL, 32'h8000_00F0, 32'd4, 32'h0800_000F, 1'b0};
    vecs[nVecs++] = '{1'b0, SLL, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 1'b1};
    vecs[nVecs++] = '{1'b0, 6'b100000, 32'h1234_5678, 32'd1, 32'h0000_0000, 1'b1};
    vecs[nVecs++] = '{1'b0, 6'b000001, 32'hFFFF_FFFF, 32'd3, 32'h0000_0000, 1'b1};
    vecs[nVecs++] = '{1'b0, SRL, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0000, 1'b1};
    vecs[nVecs++] = '{1'b0, SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0};
    vecs[nVecs++] = '{1'b0, SRA, 32'h7000_0000, 32'd31, 32'h0000_0000, 1'b0};
    vecs[nVecs++] = '{1'b0, SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[nVecs++] = '{1'b0, SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0};
    vecs[nVecs++] = '{1'b0, SLL, 32'hA5A5_A5A5, 32'd16, 32'hA5A5_0000, 1'b0};
    vecs[nVecs++] = '{1'b0, SRA, 32'hA5A5_A5A5, 32'd8, 32'hFFA5_A5A5, 1'b0};
    vecs[nVecs++] = '{1'b0, SRL, 32'h1234_5678, 32'd12, 32'h0001_2345, 1'b0};
    vecs[nVecs++] = '{1'b0, SLL, 32'h1234_5678, 32'd4, 32'h2345_6780, 1'b0};
    vecs[nVecs++] = '{1'b1, SRA, 32'h0000_0081, 32'd7, 32'h0000_00FF, 1'b0};
    vecs[nVecs++] = '{1'b1, SRA, 32'h0000_0081, 32'd8, 32'h0000_0000, 1'b1};
    vecs[nVecs++] = '{1'b1, SRL, 32'h0000_0081, 32'd7, 32'h0000_0001, 1'b0};
    vecs[nVecs++] = '{1'b1, SLL, 32'h0000_0081, 32'd1, 32'h0000_0002, 1'b0};
    vecs[nVecs++] = '{1'b1, SRA, 32'h0000_0040, 32'd3, 32'h0000_0008, 1'b0};

    // Reset state
    cyc(2);
    check("reset out_valid", {31'b0, outValid}, 32'd0);
    check("reset dataOut", dataOut, 32'd0);
    check("reset out_err", {31'b0, outErr}, 32'd0);
    check("reset out_valid8", {31'b0, outValid8}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", {31'b0, inReady}, 32'd1);
    cyc(1);

    for (int i = 0; i < nVecs; i++) begin
      runOne(i, vecs[i]);
    end

    // Back-to-back SRA then SRL must emerge on consecutive cycles in order
    inValid = 1'b1; sig = SRA; dataA = 32'h8000_00F0; dataB = 32'd4;
    cyc(1);
    sig = SRL;
    cyc(1);
    inValid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (outValid) seen = 1'b1;
      else cyc(1);
    end
    check("b2b first seen", {31'b0, seen}, 32'd1);
    check("b2b first data", dataOut, 32'hF800_000F);
    cyc(1);
    check("b2b second valid", {31'b0, outValid}, 32'd1);
    check("b2b second data", dataOut, 32'h0800_000F);
    cyc(1);
    check("b2b drained", {31'b0, outValid}, 32'd0);

    // Stream of 8 SLL ops under out_ready pattern 1,0,0,...
    received = 0;
    issued = 0;
    prevStall = 1'b0;
    prevData = '0;
    sig = SLL;
    dataA = 32'd1;
    for (int c = 0; c < 100 && received < 8; c++) begin
      outReady = (c % 3 == 0);
      inValid = (issued < 8);
      dataB = issued;
      #1;
      check($sformatf("stream c%0d in_ready", c), {31'b0, inReady},
            {31'b0, !(outValid && !outReady)});
      if (prevStall) begin
        check($sformatf("stream c%0d held valid", c), {31'b0, outValid}, 32'd1);
        check($sformatf("stream c%0d held data", c), dataOut, prevData);
      end
      if (outValid && outReady) begin
        check($sformatf("stream out%0d", received), dataOut, 32'd1 << received);
        received++;
      end
      prevStall = outValid && !outReady;
      prevData = dataOut;
      if (inValid && inReady) issued++;
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    outReady = 1'b1;
    check("stream received count", received, 32'd8);
    extra = 0;
    repeat (8) begin
      if (outValid) extra++;
      cyc(1);
    end
    check("stream no duplicates", extra, 32'd0);

    // Reset with three ops in flight
    dataA = 32'hFFFF_FFFF; dataB = '0; sig = SLL;
    cyc(6);
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1;
      dataB = i;
      cyc(1);
    end
    inValid = 1'b0;
    rst = 1'b1;
    cyc(1);
    check("midreset out_valid", {31'b0, outValid}, 32'd0);
    check("midreset dataOut", dataOut, 32'd0);
    check("midreset out_err", {31'b0, outErr}, 32'd0);
    rst = 1'b0;
    #1;
    check("midreset in_ready", {31'b0, inReady}, 32'd1);
    extra = 0;
    repeat (8) begin
      if (outValid) extra++;
      cyc(1);
    end
    check("midreset no ghost outputs", extra, 32'd0);
    runOne(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
